// File: rtl/position_controller.sv
// Per-frame position updater: moves the player square from the buttons, drops 32 obstacles
// one per cycle, respawns the ones that fall off screen and latches any overlap as a collision.
module position_controller #(
  parameter int SQ_SIZE   = 20,
  parameter int STEP      = 4,
  parameter int OBJ_SPEED = 2,
  parameter int SCREEN_W  = 640,
  parameter int SCREEN_H  = 480
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         frame_tick,
  input  logic         btn_up,
  input  logic         btn_down,
  input  logic         btn_left,
  input  logic         btn_right,
  input  logic         restart,
  output logic [659:0] position,
  output logic         busy,
  output logic         update_done,
  output logic         collision,
  output logic [15:0]  score
);
  localparam int NUM_OBJ = 32;
  localparam logic [9:0]  STEP_V  = 10'(STEP);
  localparam logic [9:0]  X_MAX   = 10'(SCREEN_W - SQ_SIZE);
  localparam logic [9:0]  Y_MAX   = 10'(SCREEN_H - SQ_SIZE);
  localparam logic [9:0]  SQ_V    = 10'(SQ_SIZE);
  localparam logic [10:0] Y_LAST  = 11'(SCREEN_H - 1);
  localparam logic [10:0] SPEED_V = 11'(OBJ_SPEED);

  typedef enum logic [1:0] {IDLE, MAIN, OBJ, DONE} state_t;

  state_t state, state_nxt;
  logic [4:0]  idx;
  logic [15:0] lfsr;
  logic [9:0]  main_x, main_y, mx_nxt, my_nxt;
  logic [NUM_OBJ-1:0][9:0] obj_x, obj_y;
  logic [9:0]  cur_x, cur_y, ox_new, oy_new, dx, dy;
  logic [10:0] oy_sum;
  logic        wrap, overlap;

  always_ff @(posedge clk) begin
    if (reset || restart) begin
      state <= IDLE;
      idx   <= '0;
    end else begin
      state <= state_nxt;
      if (state == OBJ) idx <= idx + 5'd1;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (frame_tick && !collision) state_nxt = MAIN;
      MAIN:    state_nxt = OBJ;
      OBJ:     if (idx == 5'd31) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy        = (state != IDLE);
    update_done = (state == DONE);
  end

  // Opposing buttons cancel; each axis clamps to the visible area.
  always_comb begin
    mx_nxt = main_x;
    my_nxt = main_y;
    if (btn_left && !btn_right)      mx_nxt = (main_x < STEP_V) ? '0 : main_x - STEP_V;
    else if (btn_right && !btn_left) mx_nxt = (main_x + STEP_V > X_MAX) ? X_MAX : main_x + STEP_V;
    if (btn_up && !btn_down)         my_nxt = (main_y < STEP_V) ? '0 : main_y - STEP_V;
    else if (btn_down && !btn_up)    my_nxt = (main_y + STEP_V > Y_MAX) ? Y_MAX : main_y + STEP_V;
  end

  // Obstacle under the sweep index, and its overlap test against the already-moved player.
  always_comb begin
    cur_x   = obj_x[idx];
    cur_y   = obj_y[idx];
    oy_sum  = {1'b0, cur_y} + SPEED_V;
    wrap    = (oy_sum > Y_LAST);
    ox_new  = wrap ? ((lfsr[9:0] <= X_MAX) ? lfsr[9:0] : lfsr[9:0] - 10'd512) : cur_x;
    oy_new  = wrap ? '0 : oy_sum[9:0];
    dx      = (main_x >= ox_new) ? main_x - ox_new : ox_new - main_x;
    dy      = (main_y >= oy_new) ? main_y - oy_new : oy_new - main_y;
    overlap = (dx < SQ_V) && (dy < SQ_V);
  end

  always_ff @(posedge clk) begin
    if (reset || restart) begin
      main_x    <= 10'd310;
      main_y    <= 10'd440;
      collision <= 1'b0;
      for (int i = 0; i < NUM_OBJ; i++) begin
        obj_x[i] <= 10'(20 * i);
        obj_y[i] <= 10'(14 * i);
      end
    end else if (!collision) begin
      if (state == MAIN) begin
        main_x <= mx_nxt;
        main_y <= my_nxt;
      end
      if (state == OBJ) begin
        obj_x[idx] <= ox_new;
        obj_y[idx] <= oy_new;
        if (overlap) collision <= 1'b1;
      end
    end
  end

  // Score and random source survive restart; only reset clears them.
  always_ff @(posedge clk) begin
    if (reset) begin
      lfsr  <= 16'hACE1;
      score <= '0;
    end else if (!restart && state == OBJ) begin
      lfsr <= {lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5], lfsr[15:1]};
      if (wrap && !collision && score != 16'hFFFF) score <= score + 16'd1;
    end
  end

  always_comb begin
    position[659:640] = {main_y, main_x};
    for (int i = 0; i < NUM_OBJ; i++) position[20*i +: 20] = {obj_y[i], obj_x[i]};
  end
endmodule

// File: tb/tb_position_controller.sv
// Bench for position_controller: a frame-level model applies a whole sweep at tick acceptance
// and is compared every cycle; directed scenarios pin key values with literals.
module tb_position_controller;
  logic clk = 1'b0;
  logic reset, frame_tick, btn_up, btn_down, btn_left, btn_right, restart;
  logic [659:0] position;
  logic busy, update_done, collision;
  logic [15:0] score;
  int errors = 0, checks = 0;

  always #5 clk = ~clk;

  position_controller dut (
    .clk(clk), .reset(reset), .frame_tick(frame_tick),
    .btn_up(btn_up), .btn_down(btn_down), .btn_left(btn_left), .btn_right(btn_right),
    .restart(restart), .position(position), .busy(busy), .update_done(update_done),
    .collision(collision), .score(score)
  );

  // model state
  int m_mx, m_my, m_score, m_cnt;
  int m_ox[32], m_oy[32];
  bit m_col;
  logic [15:0] m_lfsr;

  function automatic logic [15:0] lstep(input logic [15:0] l);
    return {l[0] ^ l[2] ^ l[3] ^ l[5], l[15:1]};
  endfunction

  function automatic logic [659:0] mpos();
    logic [659:0] p;
    p[649:640] = 10'(m_mx);
    p[659:650] = 10'(m_my);
    for (int i = 0; i < 32; i++) begin
      p[20*i +: 10]    = 10'(m_ox[i]);
      p[20*i+10 +: 10] = 10'(m_oy[i]);
    end
    return p;
  endfunction

  function automatic int ox(input int i); return int'(position[20*i +: 10]); endfunction
  function automatic int oy(input int i); return int'(position[20*i+10 +: 10]); endfunction
  function automatic int mx(); return int'(position[649:640]); endfunction
  function automatic int my(); return int'(position[659:650]); endfunction

  task automatic minit();
    m_mx = 310; m_my = 440; m_col = 1'b0; m_cnt = 0;
    for (int i = 0; i < 32; i++) begin m_ox[i] = 20 * i; m_oy[i] = 14 * i; end
  endtask

  // One whole frame: player move, then obstacles 0..31 in order, freezing after a hit.
  task automatic mframe();
    int ny, l;
    if (btn_up && !btn_down)      m_my = (m_my < 4) ? 0 : m_my - 4;
    else if (btn_down && !btn_up) m_my = (m_my + 4 > 460) ? 460 : m_my + 4;
    if (btn_left && !btn_right)      m_mx = (m_mx < 4) ? 0 : m_mx - 4;
    else if (btn_right && !btn_left) m_mx = (m_mx + 4 > 620) ? 620 : m_mx + 4;
    for (int i = 0; i < 32; i++) begin
      l = int'(m_lfsr[9:0]);
      if (!m_col) begin
        ny = m_oy[i] + 2;
        if (ny > 479) begin
          m_oy[i] = 0;
          m_ox[i] = (l <= 620) ? l : l - 512;
          if (m_score < 65535) m_score++;
        end else m_oy[i] = ny;
        if (m_mx - m_ox[i] < 20 && m_ox[i] - m_mx < 20 &&
            m_my - m_oy[i] < 20 && m_oy[i] - m_my < 20) m_col = 1'b1;
      end
      m_lfsr = lstep(m_lfsr);
    end
  endtask

  task automatic model_edge();
    if (reset) begin minit(); m_score = 0; m_lfsr = 16'hACE1; end
    else if (restart) minit();
    else if (m_cnt > 0) m_cnt--;
    else if (frame_tick && !m_col) begin mframe(); m_cnt = 34; end
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic compare();
    chk("busy", int'(busy), int'(m_cnt > 0));
    chk("update_done", int'(update_done), int'(m_cnt == 1));
    if (m_cnt == 0) begin
      checks++;
      if (position !== mpos()) begin
        errors++;
        $display("FAIL position: got %0h expected %0h", position, mpos());
      end
      chk("collision", int'(collision), int'(m_col));
      chk("score", int'(score), m_score);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    compare();
  endtask

  task automatic do_reset();
    reset = 1'b1; cyc(); reset = 1'b0; cyc();
  endtask

  // Tick with buttons held; optional second tick at cycle tick2 of the sweep.
  task automatic frame(input bit u, d, l, r, input int tick2, output int done_at, output int n_done);
    {btn_up, btn_down, btn_left, btn_right} = {u, d, l, r};
    frame_tick = 1'b1; done_at = 0; n_done = 0;
    for (int k = 1; k <= 36; k++) begin
      cyc();
      frame_tick = (k == tick2);
      if (update_done) begin
        n_done++;
        if (done_at == 0) done_at = k;
      end
    end
  endtask

  int da, nd;

  initial begin
    {reset, frame_tick, btn_up, btn_down, btn_left, btn_right, restart} = '0;
    reset = 1'b1; cyc(); cyc();
    reset = 1'b0; cyc();
    chk("rst_main_x", mx(), 310);
    chk("rst_main_y", my(), 440);
    chk("rst_obj31_x", ox(31), 620);
    chk("rst_obj31_y", oy(31), 434);
    chk("rst_busy", int'(busy), 0);
    chk("rst_score", int'(score), 0);

    // single left frame
    frame(0, 0, 1, 0, 0, da, nd);
    chk("left_main_x", mx(), 306);
    chk("left_obj0_y", oy(0), 2);
    chk("left_obj31_y", oy(31), 436);
    chk("done_latency", da, 34);

    // second tick mid-sweep is dropped
    do_reset();
    frame(0, 0, 1, 0, 10, da, nd);
    chk("dbl_tick_dones", nd, 1);
    chk("dbl_tick_main_x", mx(), 306);
    chk("dbl_tick_obj0_y", oy(0), 2);

    // bottom clamp, then all buttons cancel
    do_reset();
    for (int n = 0; n < 6; n++) frame(0, 1, 0, 0, 0, da, nd);
    chk("down_clamp_y", my(), 460);
    frame(1, 1, 1, 1, 0, da, nd);
    chk("cancel_x", mx(), 310);
    chk("cancel_y", my(), 460);

    // left clamp
    do_reset();
    for (int n = 0; n < 78; n++) frame(0, 0, 1, 0, 0, da, nd);
    chk("left_clamp_x", mx(), 0);
    chk("left_clamp_col", int'(collision), 0);

    // first obstacle wrap
    do_reset();
    for (int n = 0; n < 23; n++) frame(0, 0, 0, 0, 0, da, nd);
    chk("wrap_obj31_y", oy(31), 0);
    chk("wrap_score", int'(score), 1);
    chk("wrap_col", int'(collision), 0);

    // climb into obstacle 16
    do_reset();
    for (int n = 0; n < 32; n++) frame(1, 0, 0, 0, 0, da, nd);
    chk("climb32_col", int'(collision), 0);
    frame(1, 0, 0, 0, 0, da, nd);
    chk("climb33_col", int'(collision), 1);
    chk("climb33_main_y", my(), 308);
    frame(1, 0, 0, 0, 0, da, nd);
    frame(1, 0, 0, 0, 0, da, nd);
    chk("frozen_main_y", my(), 308);
    chk("frozen_obj16_y", oy(16), 290);
    restart = 1'b1; cyc(); restart = 1'b0; cyc();
    chk("restart_col", int'(collision), 0);
    chk("restart_main_y", my(), 440);
    chk("restart_obj16_y", oy(16), 224);
    chk("restart_score", int'(score), 2);
    frame(1, 0, 0, 0, 0, da, nd);
    chk("post_restart_y", my(), 436);

    // reset mid-sweep aborts it
    do_reset();
    frame_tick = 1'b1; cyc(); frame_tick = 1'b0;
    repeat (15) cyc();
    reset = 1'b1; cyc(); reset = 1'b0;
    repeat (5) cyc();
    chk("abort_main_y", my(), 440);
    chk("abort_obj0_y", oy(0), 0);
    chk("abort_obj13_y", oy(13), 182);
    chk("abort_busy", int'(busy), 0);
    frame(0, 0, 0, 0, 0, da, nd);
    chk("abort_next_obj0_y", oy(0), 2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
